// File: rtl/sensor_event_tx_if.sv
// sensor_event_tx_if: event handshake between the sensor block and the FSM.
// master drives the offered event, slave returns acceptance.
interface sensor_event_tx_if;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_ready;

    modport master (
        output evt_valid,
        output evt_code,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        output evt_ready
    );
endinterface

// File: rtl/sensor_event_tx.sv
// sensor_event_tx: sync + debounce of 4 sensor lines, rising edges queued as events.
// Optional handshake timeout: define SENSOR_EVT_TIMEOUT_EN.
module sensor_event_tx #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [3:0]        sens_raw,
    output logic [3:0]        sens_stable,
    output logic              overrun,
    output logic              evt_drop,
    sensor_event_tx_if.master evt
);
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES);

    if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
        $error("DEB_CYCLES out of range 1..255");
    end
    if (TMO_CYCLES < 1 || TMO_CYCLES > 255) begin : g_bad_tmo
        $error("TMO_CYCLES out of range 1..255");
    end

    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      stable_q, stable_d;
    logic [3:0][7:0] cnt_q, cnt_d;
    logic [3:0]      pend_q, pend_d;
    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [2:0]      code_q, code_d;
    logic            ovr_q, ovr_d;
    logic [3:0]      rise, clr;
    logic [3:0]      pick_oh;
    logic [2:0]      pick_code;
`ifdef SENSOR_EVT_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);
    logic [7:0]      tmo_q, tmo_d;
    logic            drop_q, drop_d;
`endif

    // Debounce: accept a level once it has disagreed for DEB_CYCLES counted cycles.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = 8'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end else begin
                cnt_d[i] = 8'd0;
            end
        end
    end

    // Fixed priority pick: battery_low, bump_left, bump_right, dirt.
    always_comb begin
        pick_oh   = 4'b0000;
        pick_code = 3'd0;
        if (pend_q[3]) begin
            pick_oh   = 4'b1000;
            pick_code = 3'd4;
        end else if (pend_q[0]) begin
            pick_oh   = 4'b0001;
            pick_code = 3'd1;
        end else if (pend_q[1]) begin
            pick_oh   = 4'b0010;
            pick_code = 3'd2;
        end else if (pend_q[2]) begin
            pick_oh   = 4'b0100;
            pick_code = 3'd3;
        end
    end

    // Handshake state machine next-state and registered outputs.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        code_d  = code_q;
        clr     = 4'b0000;
`ifdef SENSOR_EVT_TIMEOUT_EN
        tmo_d   = 8'd0;
        drop_d  = drop_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (ena && (|pend_q)) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    code_d  = pick_code;
                    clr     = pick_oh;
                end
            end
            SEND: begin
                if (evt.evt_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    code_d  = 3'd0;
`ifdef SENSOR_EVT_TIMEOUT_EN
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    code_d  = 3'd0;
                    drop_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                code_d  = 3'd0;
            end
        endcase
    end

    // Pending bits: a new rise wins over the clear of a bit being launched.
    always_comb begin
        rise   = stable_d & ~stable_q;
        pend_d = (pend_q & ~clr) | rise;
        ovr_d  = ovr_q | (|(rise & pend_q & ~clr));
    end

    // All state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 4'b0000;
            sync2_q  <= 4'b0000;
            stable_q <= 4'b0000;
            cnt_q    <= '0;
            pend_q   <= 4'b0000;
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            code_q   <= 3'd0;
            ovr_q    <= 1'b0;
`ifdef SENSOR_EVT_TIMEOUT_EN
            tmo_q    <= 8'd0;
            drop_q   <= 1'b0;
`endif
        end else begin
            sync1_q  <= sens_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            state_q  <= state_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            ovr_q    <= ovr_d;
`ifdef SENSOR_EVT_TIMEOUT_EN
            tmo_q    <= tmo_d;
            drop_q   <= drop_d;
`endif
        end
    end

    assign sens_stable   = stable_q;
    assign overrun       = ovr_q;
    assign evt.evt_valid = valid_q;
    assign evt.evt_code  = code_q;
`ifdef SENSOR_EVT_TIMEOUT_EN
    assign evt_drop      = drop_q;
`else
    assign evt_drop      = 1'b0;
`endif
endmodule

// File: tb/tb_sensor_event_tx.sv
// tb_sensor_event_tx: directed and random stimulus against a behavioural model.
// Define SENSOR_EVT_TIMEOUT_EN to exercise the timeout path (TMO=10).
`timescale 1ns/1ps
module tb_sensor_event_tx;
    localparam int DEB = 4;
`ifdef SENSOR_EVT_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 255;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [3:0] sens_raw = 4'h0;
    logic [3:0] sens_stable;
    logic       overrun;
    logic       evt_drop;
    int         errs = 0;
    int         checks = 0;
    int         dut_acc[$];

    sensor_event_tx_if evt_bus ();

    sensor_event_tx #(
        .DEB_CYCLES(DEB),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .sens_raw(sens_raw),
        .sens_stable(sens_stable),
        .overrun(overrun),
        .evt_drop(evt_drop),
        .evt(evt_bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [3:0] m_s1, m_s2, m_stab, m_pend;
    int         m_run[4];
    bit         m_busy, m_ovr, m_drop;
    int         m_code, m_age;
    int         order[4] = '{3, 0, 1, 2};

    function automatic int code_of(input int b);
        return (b == 3) ? 4 : b + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_stab = 0; m_pend = 0;
        foreach (m_run[i]) m_run[i] = 0;
        m_busy = 0; m_ovr = 0; m_drop = 0; m_code = 0; m_age = 0;
    endtask

    task automatic model_step(input logic [3:0] raw, input bit en, input bit rdy);
        logic [3:0] old_stab;
        logic [3:0] rise;
        old_stab = m_stab;
        // a level is accepted after DEB+1 consecutive disagreeing samples
        for (int b = 0; b < 4; b++) begin
            if (m_s2[b] != m_stab[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB + 1) begin
                    m_stab[b] = m_s2[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
        rise = m_stab & ~old_stab;
        if (m_busy) begin
            if (rdy) begin
                m_busy = 0;
`ifdef SENSOR_EVT_TIMEOUT_EN
            end else begin
                m_age++;
                if (m_age == TMO) begin
                    m_busy = 0;
                    m_drop = 1;
                end
`endif
            end
        end else if (en && m_pend != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (!m_busy && m_pend[order[i]]) begin
                    m_busy = 1;
                    m_code = code_of(order[i]);
                    m_pend[order[i]] = 0;
                    m_age = 0;
                end
            end
        end
        for (int b = 0; b < 4; b++) begin
            if (rise[b]) begin
                if (m_pend[b]) m_ovr = 1;
                m_pend[b] = 1;
            end
        end
    endtask

    task automatic cmp_all();
        check("stable", sens_stable, m_stab);
        check("valid", evt_bus.evt_valid, m_busy);
        check("code", evt_bus.evt_code, m_busy ? m_code : 0);
        check("overrun", overrun, m_ovr);
        check("drop", evt_drop, m_drop);
    endtask

    // called at a negedge; returns at the following negedge
    task automatic cyc(input logic [3:0] raw, input bit en, input bit rdy);
        sens_raw = raw;
        ena = en;
        evt_bus.evt_ready = rdy;
        if (evt_bus.evt_valid && rdy) dut_acc.push_back(int'(evt_bus.evt_code));
        @(posedge clk);
        model_step(raw, en, rdy);
        #1;
        cmp_all();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic settle();
        for (int i = 0; i < 12; i++) cyc(4'h0, 1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int first_hi, st_hi, seen, hi_cnt, rises;
        bit prev_v, got;
        logic [3:0] r;
        evt_bus.evt_ready = 1'b1;
        @(negedge clk);
        apply_reset();

        // single dirt event, latency from steady input
        dut_acc.delete();
        first_hi = -1; st_hi = -1;
        for (int k = 0; k < 20; k++) begin
            cyc(4'b0100, 1'b1, 1'b1);
            if (first_hi < 0 && evt_bus.evt_valid) first_hi = k;
            if (st_hi < 0 && sens_stable[2]) st_hi = k;
        end
        check("lat_stable", st_hi, 2 + DEB);
        check("lat_valid", first_hi, 3 + DEB);
        check("dirt_count", dut_acc.size(), 1);
        check("dirt_code", (dut_acc.size() > 0) ? dut_acc[0] : -1, 3);
        settle();

        // 3-cycle glitch on bump_left
        dut_acc.delete();
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            cyc((k < 3) ? 4'b0001 : 4'b0000, 1'b1, 1'b1);
            if (sens_stable[0]) seen = 1;
        end
        check("glitch_stable", seen, 0);
        check("glitch_evt", dut_acc.size(), 0);

        // battery_low and bump_left together
        dut_acc.delete();
        rises = 0; prev_v = 0;
        for (int k = 0; k < 25; k++) begin
            cyc(4'b1001, 1'b1, 1'b1);
            if (evt_bus.evt_valid && !prev_v) rises++;
            prev_v = evt_bus.evt_valid;
        end
        check("pair_count", dut_acc.size(), 2);
        check("pair_first", (dut_acc.size() > 0) ? dut_acc[0] : -1, 4);
        check("pair_second", (dut_acc.size() > 1) ? dut_acc[1] : -1, 1);
        check("pair_gap", rises, 2);
        settle();

`ifndef SENSOR_EVT_TIMEOUT_EN
        // held event while bump_right toggles twice
        for (int k = 0; k < 12; k++) cyc(4'b0010, 1'b1, 1'b0);
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 8; k++) cyc(4'b0000, 1'b1, 1'b0);
            for (int k = 0; k < 8; k++) cyc(4'b0010, 1'b1, 1'b0);
        end
        check("hold_code", evt_bus.evt_code, 2);
        check("hold_ovr", overrun, 1);
        dut_acc.delete();
        for (int k = 0; k < 15; k++) cyc(4'b0010, 1'b1, 1'b1);
        check("ovr_count", dut_acc.size(), 2);
        settle();
`else
        // timeout with ready held low
        hi_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(4'b0100, 1'b1, 1'b0);
            if (evt_bus.evt_valid) hi_cnt++;
        end
        check("tmo_len", hi_cnt, TMO);
        check("tmo_drop", evt_drop, 1);
        settle();
`endif
        @(negedge clk);
        apply_reset();

        // ena low blocks launch only
        dut_acc.delete();
        hi_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            cyc(4'b0001, 1'b0, 1'b1);
            if (evt_bus.evt_valid) hi_cnt++;
        end
        check("ena_block", hi_cnt, 0);
        for (int k = 0; k < 5; k++) cyc(4'b0001, 1'b1, 1'b1);
        check("ena_count", dut_acc.size(), 1);
        check("ena_code", (dut_acc.size() > 0) ? dut_acc[0] : -1, 1);
        settle();

        // reset in the middle of SEND
        got = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            cyc(4'b1000, 1'b1, 1'b0);
            got = evt_bus.evt_valid;
        end
        check("rst_send", got, 1);
        rst_n = 1'b0;
        #1;
        check("rst_valid", evt_bus.evt_valid, 0);
        check("rst_code", evt_bus.evt_code, 0);
        check("rst_stable", sens_stable, 0);
        check("rst_flags", {overrun, evt_drop}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        dut_acc.delete();
        first_hi = -1;
        for (int k = 0; k < 20; k++) begin
            cyc(4'b1000, 1'b1, 1'b1);
            if (first_hi < 0 && evt_bus.evt_valid) first_hi = k;
        end
        check("rst_relat", first_hi, 3 + DEB);
        check("rst_recode", (dut_acc.size() > 0) ? dut_acc[0] : -1, 4);
        settle();

        // random traffic against the model
        r = 4'h0;
        for (int n = 0; n < 60; n++) begin
            r = 4'($urandom_range(0, 15));
            for (int k = 0; k < int'($urandom_range(1, 12)); k++)
                cyc(r, ($urandom % 8) != 0, ($urandom % 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
